// File: rtl/scica_cordic_result_router_if.sv
// Issue, CORDIC-return and routed-result bundle for the SCICA CORDIC result router.
// Optional statistics ports are present only when SCICA_ROUTER_STATS_EN is defined.
interface scica_cordic_result_router_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ANGLE_WIDTH   = 16,
  parameter int unsigned CORDIC_STAGES = 16
);
  // issue side
  logic [1:0]               scica_stage_in;
  logic                     vec_issue;
  logic                     rot1_issue;
  logic                     rot2_issue;
  // CORDIC return side
  logic                     cordic_vec_opvld;
  logic [DATA_WIDTH-1:0]    cordic_vec_xout;
  logic [ANGLE_WIDTH-1:0]   cordic_vec_angle_out;
  logic [CORDIC_STAGES-1:0] cordic_vec_microRot_out;
  logic [1:0]               cordic_vec_quad_out;
  logic                     cordic_rot1_opvld;
  logic                     cordic_rot2_opvld;
  logic [DATA_WIDTH-1:0]    cordic_rot1_xout;
  logic [DATA_WIDTH-1:0]    cordic_rot1_yout;
  logic [DATA_WIDTH-1:0]    cordic_rot2_xout;
  logic [DATA_WIDTH-1:0]    cordic_rot2_yout;
  logic                     err_clr;
  // routed results
  logic                     evd_vec_vld;
  logic                     ica_vec_vld;
  logic                     kmeans_vec_vld;
  logic [DATA_WIDTH-1:0]    vec_xout;
  logic [ANGLE_WIDTH-1:0]   vec_angle_out;
  logic [CORDIC_STAGES-1:0] vec_microRot_out;
  logic [1:0]               vec_quad_out;
  logic                     evd_rot1_vld;
  logic                     ica_rot1_vld;
  logic                     fft_rot_vld;
  logic [DATA_WIDTH-1:0]    rot1_xout;
  logic [DATA_WIDTH-1:0]    rot1_yout;
  logic                     evd_rot2_vld;
  logic                     ica_rot2_vld;
  logic [DATA_WIDTH-1:0]    rot2_xout;
  logic [DATA_WIDTH-1:0]    rot2_yout;
  logic                     err_overflow;
  logic                     err_underflow;
  logic                     err_badtag;
`ifdef SCICA_ROUTER_STATS_EN
  logic [31:0]              stat_evd_cnt;
  logic [31:0]              stat_ica_cnt;
  logic [31:0]              stat_fft_cnt;
  logic [31:0]              stat_kmeans_cnt;

  modport master (
    output scica_stage_in, vec_issue, rot1_issue, rot2_issue,
    output cordic_vec_opvld, cordic_vec_xout, cordic_vec_angle_out,
    output cordic_vec_microRot_out, cordic_vec_quad_out,
    output cordic_rot1_opvld, cordic_rot2_opvld,
    output cordic_rot1_xout, cordic_rot1_yout, cordic_rot2_xout, cordic_rot2_yout,
    output err_clr,
    input  evd_vec_vld, ica_vec_vld, kmeans_vec_vld,
    input  vec_xout, vec_angle_out, vec_microRot_out, vec_quad_out,
    input  evd_rot1_vld, ica_rot1_vld, fft_rot_vld, rot1_xout, rot1_yout,
    input  evd_rot2_vld, ica_rot2_vld, rot2_xout, rot2_yout,
    input  err_overflow, err_underflow, err_badtag,
    input  stat_evd_cnt, stat_ica_cnt, stat_fft_cnt, stat_kmeans_cnt
  );

  modport slave (
    input  scica_stage_in, vec_issue, rot1_issue, rot2_issue,
    input  cordic_vec_opvld, cordic_vec_xout, cordic_vec_angle_out,
    input  cordic_vec_microRot_out, cordic_vec_quad_out,
    input  cordic_rot1_opvld, cordic_rot2_opvld,
    input  cordic_rot1_xout, cordic_rot1_yout, cordic_rot2_xout, cordic_rot2_yout,
    input  err_clr,
    output evd_vec_vld, ica_vec_vld, kmeans_vec_vld,
    output vec_xout, vec_angle_out, vec_microRot_out, vec_quad_out,
    output evd_rot1_vld, ica_rot1_vld, fft_rot_vld, rot1_xout, rot1_yout,
    output evd_rot2_vld, ica_rot2_vld, rot2_xout, rot2_yout,
    output err_overflow, err_underflow, err_badtag,
    output stat_evd_cnt, stat_ica_cnt, stat_fft_cnt, stat_kmeans_cnt
  );
`else
  modport master (
    output scica_stage_in, vec_issue, rot1_issue, rot2_issue,
    output cordic_vec_opvld, cordic_vec_xout, cordic_vec_angle_out,
    output cordic_vec_microRot_out, cordic_vec_quad_out,
    output cordic_rot1_opvld, cordic_rot2_opvld,
    output cordic_rot1_xout, cordic_rot1_yout, cordic_rot2_xout, cordic_rot2_yout,
    output err_clr,
    input  evd_vec_vld, ica_vec_vld, kmeans_vec_vld,
    input  vec_xout, vec_angle_out, vec_microRot_out, vec_quad_out,
    input  evd_rot1_vld, ica_rot1_vld, fft_rot_vld, rot1_xout, rot1_yout,
    input  evd_rot2_vld, ica_rot2_vld, rot2_xout, rot2_yout,
    input  err_overflow, err_underflow, err_badtag
  );

  modport slave (
    input  scica_stage_in, vec_issue, rot1_issue, rot2_issue,
    input  cordic_vec_opvld, cordic_vec_xout, cordic_vec_angle_out,
    input  cordic_vec_microRot_out, cordic_vec_quad_out,
    input  cordic_rot1_opvld, cordic_rot2_opvld,
    input  cordic_rot1_xout, cordic_rot1_yout, cordic_rot2_xout, cordic_rot2_yout,
    input  err_clr,
    output evd_vec_vld, ica_vec_vld, kmeans_vec_vld,
    output vec_xout, vec_angle_out, vec_microRot_out, vec_quad_out,
    output evd_rot1_vld, ica_rot1_vld, fft_rot_vld, rot1_xout, rot1_yout,
    output evd_rot2_vld, ica_rot2_vld, rot2_xout, rot2_yout,
    output err_overflow, err_underflow, err_badtag
  );
`endif
endinterface

// File: rtl/scica_cordic_result_router.sv
// Routes in-order CORDIC results back to the issuing SCICA stage using one tag FIFO per channel.
// Optional per-stage result counters are enabled with `define SCICA_ROUTER_STATS_EN.
module scica_cordic_result_router #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ANGLE_WIDTH   = 16,
  parameter int unsigned CORDIC_STAGES = 16,
  parameter int unsigned TAG_DEPTH     = 32
) (
  input logic clk,
  input logic nreset,
  scica_cordic_result_router_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NCH   = 3;
  localparam int unsigned VEC   = 0;
  localparam int unsigned ROT1  = 1;
  localparam int unsigned ROT2  = 2;

  logic [1:0]       tag_mem [NCH][TAG_DEPTH];
  logic [PTR_W-1:0] wptr    [NCH];
  logic [PTR_W-1:0] rptr    [NCH];
  logic [CNT_W-1:0] cnt     [NCH];
  logic [1:0]       head    [NCH];

  logic [NCH-1:0] issue, opvld, empty, full, do_push, do_pop;
  logic           ovf_evt_c, udf_evt_c, bad_evt_c;
  logic           evd_vec_c, ica_vec_c, kmeans_vec_c;
  logic           evd_rot1_c, ica_rot1_c, fft_rot_c;
  logic           evd_rot2_c, ica_rot2_c;

  assign issue = {bus.rot2_issue, bus.rot1_issue, bus.vec_issue};
  assign opvld = {bus.cordic_rot2_opvld, bus.cordic_rot1_opvld, bus.cordic_vec_opvld};

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    empty   = '0;
    full    = '0;
    do_pop  = '0;
    do_push = '0;
    for (int c = 0; c < NCH; c++) begin
      head[c]    = tag_mem[c][rptr[c]];
      empty[c]   = (cnt[c] == CNT_W'(0));
      full[c]    = (cnt[c] == CNT_W'(TAG_DEPTH));
      do_pop[c]  = opvld[c] && !empty[c];
      do_push[c] = issue[c] && (!full[c] || do_pop[c]);
    end
    ovf_evt_c = |(issue & full & ~do_pop);
    udf_evt_c = |(opvld & empty);
  end

  // Stage decode per channel; tags outside a channel's legal set are consumed as bad.
  always_comb begin
    evd_vec_c    = do_pop[VEC]  && (head[VEC]  == 2'b00);
    ica_vec_c    = do_pop[VEC]  && (head[VEC]  == 2'b01);
    kmeans_vec_c = do_pop[VEC]  && (head[VEC]  == 2'b11);
    evd_rot1_c   = do_pop[ROT1] && (head[ROT1] == 2'b00);
    ica_rot1_c   = do_pop[ROT1] && (head[ROT1] == 2'b01);
    fft_rot_c    = do_pop[ROT1] && (head[ROT1] == 2'b10);
    evd_rot2_c   = do_pop[ROT2] && (head[ROT2] == 2'b00);
    ica_rot2_c   = do_pop[ROT2] && (head[ROT2] == 2'b01);
    bad_evt_c    = (do_pop[VEC]  && (head[VEC]  == 2'b10)) ||
                   (do_pop[ROT1] && (head[ROT1] == 2'b11)) ||
                   (do_pop[ROT2] && head[ROT2][1]);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (do_push[c]) tag_mem[c][wptr[c]] <= bus.scica_stage_in;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (do_push[c]) wptr[c] <= wptr[c] + PTR_W'(1);
        if (do_pop[c])  rptr[c] <= rptr[c] + PTR_W'(1);
        cnt[c] <= cnt[c] + CNT_W'(do_push[c]) - CNT_W'(do_pop[c]);
      end
    end
  end

  // Registered strobes and data; data only updates on a legally routed result.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.evd_vec_vld      <= 1'b0;
      bus.ica_vec_vld      <= 1'b0;
      bus.kmeans_vec_vld   <= 1'b0;
      bus.evd_rot1_vld     <= 1'b0;
      bus.ica_rot1_vld     <= 1'b0;
      bus.fft_rot_vld      <= 1'b0;
      bus.evd_rot2_vld     <= 1'b0;
      bus.ica_rot2_vld     <= 1'b0;
      bus.vec_xout         <= '0;
      bus.vec_angle_out    <= '0;
      bus.vec_microRot_out <= '0;
      bus.vec_quad_out     <= '0;
      bus.rot1_xout        <= '0;
      bus.rot1_yout        <= '0;
      bus.rot2_xout        <= '0;
      bus.rot2_yout        <= '0;
    end else begin
      bus.evd_vec_vld    <= evd_vec_c;
      bus.ica_vec_vld    <= ica_vec_c;
      bus.kmeans_vec_vld <= kmeans_vec_c;
      bus.evd_rot1_vld   <= evd_rot1_c;
      bus.ica_rot1_vld   <= ica_rot1_c;
      bus.fft_rot_vld    <= fft_rot_c;
      bus.evd_rot2_vld   <= evd_rot2_c;
      bus.ica_rot2_vld   <= ica_rot2_c;
      if (evd_vec_c || ica_vec_c || kmeans_vec_c) begin
        bus.vec_xout         <= bus.cordic_vec_xout;
        bus.vec_angle_out    <= bus.cordic_vec_angle_out;
        bus.vec_microRot_out <= bus.cordic_vec_microRot_out;
        bus.vec_quad_out     <= bus.cordic_vec_quad_out;
      end
      if (evd_rot1_c || ica_rot1_c || fft_rot_c) begin
        bus.rot1_xout <= bus.cordic_rot1_xout;
        bus.rot1_yout <= bus.cordic_rot1_yout;
      end
      if (evd_rot2_c || ica_rot2_c) begin
        bus.rot2_xout <= bus.cordic_rot2_xout;
        bus.rot2_yout <= bus.cordic_rot2_yout;
      end
    end
  end

  // Sticky errors: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.err_overflow  <= 1'b0;
      bus.err_underflow <= 1'b0;
      bus.err_badtag    <= 1'b0;
    end else begin
      bus.err_overflow  <= ovf_evt_c | (bus.err_overflow  & ~bus.err_clr);
      bus.err_underflow <= udf_evt_c | (bus.err_underflow & ~bus.err_clr);
      bus.err_badtag    <= bad_evt_c | (bus.err_badtag    & ~bus.err_clr);
    end
  end

`ifdef SCICA_ROUTER_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] sum;
    sum = 33'(v) + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [1:0] evd_inc_c, ica_inc_c;

  assign evd_inc_c = 2'(evd_vec_c) + 2'(evd_rot1_c) + 2'(evd_rot2_c);
  assign ica_inc_c = 2'(ica_vec_c) + 2'(ica_rot1_c) + 2'(ica_rot2_c);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bus.stat_evd_cnt    <= '0;
      bus.stat_ica_cnt    <= '0;
      bus.stat_fft_cnt    <= '0;
      bus.stat_kmeans_cnt <= '0;
    end else if (bus.err_clr) begin
      bus.stat_evd_cnt    <= '0;
      bus.stat_ica_cnt    <= '0;
      bus.stat_fft_cnt    <= '0;
      bus.stat_kmeans_cnt <= '0;
    end else begin
      bus.stat_evd_cnt    <= sat_add(bus.stat_evd_cnt, evd_inc_c);
      bus.stat_ica_cnt    <= sat_add(bus.stat_ica_cnt, ica_inc_c);
      bus.stat_fft_cnt    <= sat_add(bus.stat_fft_cnt, 2'(fft_rot_c));
      bus.stat_kmeans_cnt <= sat_add(bus.stat_kmeans_cnt, 2'(kmeans_vec_c));
    end
  end
`endif

endmodule

// File: doc/scica_cordic_result_router.md
Name: scica_cordic_result_router

Overview:
Return path of the shared SCICA CORDIC resources. Tracks which SCICA stage (EVD/ICA/FFT/k-Means) issued each request into the vectoring, rotation-1 and rotation-2 CORDIC channels. Demultiplexes each returning CORDIC result to that stage with a per-stage valid strobe. One in-order tag FIFO per channel; the CORDIC pipelines are in-order, so the oldest tag always matches the next result.

Parameters:
DATA_WIDTH, 16, width of CORDIC x/y results
ANGLE_WIDTH, 16, width of vectoring angle result
CORDIC_STAGES, 16, width of micro-rotation direction vector
TAG_DEPTH, 32, entries per tag FIFO (power of 2, >=2); must be >= max requests in flight per channel

Ports:
clk  in  1  clock, rising edge
nreset  in  1  asynchronous active-low reset
scica_stage_in  in  2  stage issuing this cycle (00 EVD, 01 ICA, 10 FFT, 11 k-Means)
vec_issue  in  1  vectoring request issued this cycle (registered cordic_vec_en)
rot1_issue  in  1  rotation-1 request issued this cycle
rot2_issue  in  1  rotation-2 request issued this cycle
cordic_vec_opvld  in  1  vectoring result valid
cordic_vec_xout  in  DATA_WIDTH  vectoring magnitude
cordic_vec_angle_out  in  ANGLE_WIDTH  vectoring angle
cordic_vec_microRot_out  in  CORDIC_STAGES  micro-rotation directions
cordic_vec_quad_out  in  2  quadrant
cordic_rot1_opvld / cordic_rot2_opvld  in  1 each  rotation result valid
cordic_rot1_xout, cordic_rot1_yout, cordic_rot2_xout, cordic_rot2_yout  in  DATA_WIDTH each  rotation results
err_clr  in  1  clears sticky error flags
evd_vec_vld, ica_vec_vld, kmeans_vec_vld  out  1 each  routed vectoring valid
vec_xout, vec_angle_out, vec_microRot_out, vec_quad_out  out  as inputs  registered vectoring result
evd_rot1_vld, ica_rot1_vld, fft_rot_vld  out  1 each  routed rotation-1 valid
rot1_xout, rot1_yout  out  DATA_WIDTH  registered rotation-1 result
evd_rot2_vld, ica_rot2_vld  out  1 each  routed rotation-2 valid
rot2_xout, rot2_yout  out  DATA_WIDTH  registered rotation-2 result
err_overflow, err_underflow, err_badtag  out  1 each  sticky error flags

Behaviour:
- Reset (async, nreset low): all valids, data outputs, error flags and FIFO pointers/counts = 0. Reset mid-operation discards all in-flight tags; results arriving after reset release with no tag raise err_underflow.
- Issue: on rising edge with X_issue=1, push scica_stage_in into channel X tag FIFO. Each channel is independent; all three may push in the same cycle.
- Return: on rising edge with cordic_X_opvld=1 and channel count>0, pop the head tag. Register the result data and assert exactly one stage valid for 1 cycle. Latency opvld -> routed valid = 1 cycle. Data outputs hold their last value when no result is routed.
- Legal tags: vec {00,01,11}; rot1 {00,01,10}; rot2 {00,01}. Popping an illegal tag consumes the entry, asserts no valid, and sets err_badtag.
- Simultaneous push+pop, count>0: both happen; count unchanged; accepted even when full.
- Push when full without pop: push dropped, err_overflow set.
- opvld with count=0: result dropped, err_underflow set. A same-cycle push is still accepted (no bypass).
- Pointers wrap modulo TAG_DEPTH; count is ceil(log2(TAG_DEPTH))+1 bits.
- Error flags: sticky. err_clr=1 clears them on the next edge; a new error event in the same cycle wins (flag stays 1).

Optional Feature:
SCICA_ROUTER_STATS_EN
- Defined: adds outputs stat_evd_cnt, stat_ica_cnt, stat_fft_cnt, stat_kmeans_cnt (32 bits each). Each counts routed results per stage across all channels (max +3/cycle for EVD/ICA). Counters saturate at all-ones, reset to 0, and clear on err_clr.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Issue vec with stage 00, then 01, then 11; return 3 opvld with xout 0x0100/0x0200/0x0300 -> evd_vec_vld, ica_vec_vld, kmeans_vec_vld each 1 cycle after the matching opvld, in that order, vec_xout matching; no errors.
- TAG_DEPTH=4: issue 5 rot1 requests (stage 10) with no returns -> err_overflow=1 after the 5th; return 4 results -> 4 fft_rot_vld pulses, then count=0.
- rot2 opvld with empty FIFO -> no valid, err_underflow=1; err_clr pulse -> flag 0 next cycle.
- Issue rot2 with stage 11 and return its result -> no valid output, err_badtag=1, FIFO count back to 0.
- FIFO full with TAG_DEPTH=4, same-cycle rot1 issue and opvld -> head tag routed, new tag accepted, count stays 4, err_overflow=0.
- Assert nreset low with 3 vec tags in flight, release, then opvld -> no valid, err_underflow=1, all outputs 0 during reset.
